// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART constants, FSM state encoding and baud select codes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_W = 8;

  localparam int BAUD_SEL_W = 3;
  localparam logic [BAUD_SEL_W-1:0] BAUD_SEL_1200   = 3'b000;
  localparam logic [BAUD_SEL_W-1:0] BAUD_SEL_2400   = 3'b001;
  localparam logic [BAUD_SEL_W-1:0] BAUD_SEL_4800   = 3'b010;
  localparam logic [BAUD_SEL_W-1:0] BAUD_SEL_9600   = 3'b011;
  localparam logic [BAUD_SEL_W-1:0] BAUD_SEL_19200  = 3'b100;
  localparam logic [BAUD_SEL_W-1:0] BAUD_SEL_38400  = 3'b101;
  localparam logic [BAUD_SEL_W-1:0] BAUD_SEL_57600  = 3'b110;
  localparam logic [BAUD_SEL_W-1:0] BAUD_SEL_115200 = 3'b111;

  localparam int ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE      = 2'd0;
  localparam logic [ST_W-1:0] ST_WRITE     = 2'd1;
  localparam logic [ST_W-1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [ST_W-1:0] ST_WAIT_DONE = 2'd3;

  typedef enum logic [ST_W-1:0] {
    S_IDLE      = ST_IDLE,
    S_WRITE     = ST_WRITE,
    S_WAIT_BUSY = ST_WAIT_BUSY,
    S_WAIT_DONE = ST_WAIT_DONE
  } echo_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_echo_responder_if.sv
// ============================================================================
// Module : uart_echo_responder_if
// Brief  : Receiver-side and transmitter-side signals of the echo responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface uart_echo_responder_if;
  import uart_pkg::*;

  logic [UART_DATA_W-1:0] Rx_DATA;
  logic                   Rx_VALID;
  logic                   Rx_FERROR;
  logic                   Rx_PERROR;
  logic                   Tx_BUSY;
  logic [UART_DATA_W-1:0] Tx_DATA;
  logic                   Tx_WR;

  // master = the UART pair around the responder, slave = the responder
  modport master (
    output Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR, Tx_BUSY,
    input  Tx_DATA, Tx_WR
  );

  modport slave (
    input  Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR, Tx_BUSY,
    output Tx_DATA, Tx_WR
  );

endinterface

`default_nettype wire

// File: rtl/uart_echo_responder_fifo.sv
// ============================================================================
// Module : uart_sync_fifo
// Brief  : Single-clock FIFO with extra-MSB pointers for full/empty detection.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     i_push,
  input  wire logic [WIDTH-1:0]         i_wdata,
  input  wire logic                     i_pop,
  output logic      [WIDTH-1:0]         o_rdata,
  output logic                          o_full,
  output logic                          o_empty,
  output logic      [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  // A pop frees the head slot this cycle, so a full FIFO may still accept
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

`default_nettype wire

// File: rtl/uart_echo_responder.sv
// ============================================================================
// Module : uart_echo_responder
// Brief  : Buffers clean received bytes and replays them to the transmitter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_echo_responder
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic               En,
  uart_echo_responder_if.slave    bus,
  output logic                    Fifo_FULL,
  output logic                    Fifo_EMPTY,
  output logic      [CNT_W-1:0]   Drop_CNT,
  output logic      [CNT_W-1:0]   Err_CNT
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  echo_state_t            r_state;
  logic                   r_valid_q;
  logic [UART_DATA_W-1:0] r_tx_data;
  logic                   r_tx_wr;
  logic [CNT_W-1:0]       r_drop_cnt;
  logic [CNT_W-1:0]       r_err_cnt;

  logic [UART_DATA_W-1:0] w_head;
  logic [AW:0]            w_count;
  logic                   w_capture;
  logic                   w_bad;
  logic                   w_pop;
  logic                   w_room;
  logic                   w_push;
  logic                   w_drop;

  // Rising edge of Rx_VALID only, so a held level counts as one byte
  assign w_capture = bus.Rx_VALID && !r_valid_q;
  assign w_bad     = bus.Rx_FERROR || bus.Rx_PERROR;
  assign w_pop     = (r_state == S_IDLE) && En && !Fifo_EMPTY && !bus.Tx_BUSY;
  assign w_room    = (w_count < c_depth) || w_pop;
  assign w_push    = w_capture && !w_bad && w_room;
  assign w_drop    = w_capture && !w_bad && !w_room;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_wdata (bus.Rx_DATA),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (Fifo_FULL),
    .o_empty (Fifo_EMPTY),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_valid_q  <= 1'b0;
      r_tx_data  <= '0;
      r_tx_wr    <= 1'b0;
      r_drop_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_valid_q <= bus.Rx_VALID;

      if (w_capture && w_bad && !(&r_err_cnt)) r_err_cnt  <= r_err_cnt + 1'b1;
      if (w_drop && !(&r_drop_cnt))            r_drop_cnt <= r_drop_cnt + 1'b1;

      // Strobe is registered off WRITE: it is high for one cycle, two edges after capture
      r_tx_wr <= (r_state == S_WRITE);

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_tx_data <= w_head;
            r_state   <= S_WRITE;
          end
        end
        S_WRITE:     r_state <= S_WAIT_BUSY;
        S_WAIT_BUSY: if (bus.Tx_BUSY)  r_state <= S_WAIT_DONE;
        S_WAIT_DONE: if (!bus.Tx_BUSY) r_state <= S_IDLE;
        default:     r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.Tx_DATA = r_tx_data;
  assign bus.Tx_WR   = r_tx_wr;
  assign Drop_CNT    = r_drop_cnt;
  assign Err_CNT     = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_uart_echo_responder.sv
// ============================================================================
// Module : tb_uart_echo_responder
// Brief  : Directed bench with a behavioural transmitter on the Tx side.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_uart_echo_responder;

  localparam int BUSY_CYC = 8;

  logic       clk;
  logic       reset;
  logic       En;
  logic       Fifo_FULL;
  logic       Fifo_EMPTY;
  logic [7:0] Drop_CNT;
  logic [7:0] Err_CNT;

  int         n_vec;
  int         n_err;
  int         n_wr;
  logic [7:0] rxq[$];

  uart_echo_responder_if u_if ();

  uart_echo_responder #(
    .DEPTH (4),
    .CNT_W (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .En         (En),
    .bus        (u_if.slave),
    .Fifo_FULL  (Fifo_FULL),
    .Fifo_EMPTY (Fifo_EMPTY),
    .Drop_CNT   (Drop_CNT),
    .Err_CNT    (Err_CNT)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transmitter stand-in: records each strobed byte then stays busy for a frame
  initial begin
    n_wr = 0;
    u_if.Tx_BUSY = 1'b0;
    forever begin
      @(negedge clk);
      if (u_if.Tx_WR === 1'b1) begin
        rxq.push_back(u_if.Tx_DATA);
        n_wr++;
        u_if.Tx_BUSY = 1'b1;
        repeat (BUSY_CYC) @(negedge clk);
        u_if.Tx_BUSY = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] d, input logic fe, input logic pe, input int hold);
    @(negedge clk);
    u_if.Rx_DATA   = d;
    u_if.Rx_FERROR = fe;
    u_if.Rx_PERROR = pe;
    u_if.Rx_VALID  = 1'b1;
    repeat (hold) @(negedge clk);
    u_if.Rx_VALID  = 1'b0;
    u_if.Rx_FERROR = 1'b0;
    u_if.Rx_PERROR = 1'b0;
  endtask

  task automatic wait_wr(input int target, input string tag);
    int k;
    for (k = 0; k < 400 && n_wr < target; k++) @(negedge clk);
    while (u_if.Tx_BUSY) @(negedge clk);
    repeat (3) @(negedge clk);
    n_vec++;
    if (n_wr != target) begin
      n_err++;
      $display("FAIL %s_wr_count: got %0d want %0d", tag, n_wr, target);
    end
  endtask

  task automatic test_reset;
    n_vec++; if (u_if.Tx_WR !== 1'b0)  begin n_err++; $display("FAIL reset_tx_wr: got %b want 0", u_if.Tx_WR); end
    n_vec++; if (u_if.Tx_DATA !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h want 00", u_if.Tx_DATA); end
    n_vec++; if (Fifo_EMPTY !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", Fifo_EMPTY); end
    n_vec++; if (Fifo_FULL !== 1'b0)  begin n_err++; $display("FAIL reset_full: got %b want 0", Fifo_FULL); end
    n_vec++; if (Drop_CNT !== 8'h00)  begin n_err++; $display("FAIL reset_drop: got %h want 00", Drop_CNT); end
    n_vec++; if (Err_CNT !== 8'h00)   begin n_err++; $display("FAIL reset_err: got %h want 00", Err_CNT); end
  endtask

  task automatic test_single;
    int base;
    base = n_wr;
    En = 1'b1;
    send(8'hA5, 1'b0, 1'b0, 1);
    n_vec++; if (u_if.Tx_WR !== 1'b0) begin n_err++; $display("FAIL single_wr_e0: got %b want 0", u_if.Tx_WR); end
    @(negedge clk);
    n_vec++; if (u_if.Tx_WR !== 1'b0) begin n_err++; $display("FAIL single_wr_e1: got %b want 0", u_if.Tx_WR); end
    @(negedge clk);
    n_vec++; if (u_if.Tx_WR !== 1'b1) begin n_err++; $display("FAIL single_wr_e2: got %b want 1", u_if.Tx_WR); end
    n_vec++; if (u_if.Tx_DATA !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h want a5", u_if.Tx_DATA); end
    @(negedge clk);
    n_vec++; if (u_if.Tx_WR !== 1'b0) begin n_err++; $display("FAIL single_wr_e3: got %b want 0", u_if.Tx_WR); end
    wait_wr(base + 1, "single");
    n_vec++; if (rxq[base] !== 8'hA5) begin n_err++; $display("FAIL single_echo: got %h want a5", rxq[base]); end
    n_vec++; if (Err_CNT !== 8'h00 || Drop_CNT !== 8'h00) begin n_err++; $display("FAIL single_counters: got err=%h drop=%h want 00/00", Err_CNT, Drop_CNT); end
  endtask

  task automatic test_fill;
    int base;
    logic [7:0] exp_b [5];
    exp_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
    base = n_wr;
    En = 1'b0;
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0, 1'b0, 1);
    n_vec++; if (Fifo_FULL !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b want 1", Fifo_FULL); end
    send(8'h05, 1'b0, 1'b0, 1);
    n_vec++; if (Drop_CNT !== 8'h01) begin n_err++; $display("FAIL fill_drop: got %h want 01", Drop_CNT); end
    // Enable and capture on the same edge: pop and push together keep the FIFO full
    @(negedge clk);
    En = 1'b1;
    u_if.Rx_DATA  = 8'h06;
    u_if.Rx_VALID = 1'b1;
    @(negedge clk);
    u_if.Rx_VALID = 1'b0;
    n_vec++; if (Fifo_FULL !== 1'b1) begin n_err++; $display("FAIL fill_pushpop_full: got %b want 1", Fifo_FULL); end
    n_vec++; if (Drop_CNT !== 8'h01) begin n_err++; $display("FAIL fill_pushpop_drop: got %h want 01", Drop_CNT); end
    wait_wr(base + 5, "fill");
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (rxq.size() <= base + i || rxq[base+i] !== exp_b[i]) begin
        n_err++;
        $display("FAIL fill_order[%0d]: got %h want %h", i, (rxq.size() > base + i) ? rxq[base+i] : 8'hxx, exp_b[i]);
      end
    end
    n_vec++; if (Fifo_EMPTY !== 1'b1) begin n_err++; $display("FAIL fill_empty_end: got %b want 1", Fifo_EMPTY); end
  endtask

  task automatic test_errors;
    int base;
    base = n_wr;
    send(8'h3C, 1'b0, 1'b1, 1);
    send(8'hC3, 1'b1, 1'b0, 1);
    repeat (20) @(negedge clk);
    n_vec++; if (Err_CNT !== 8'h02)   begin n_err++; $display("FAIL err_count: got %h want 02", Err_CNT); end
    n_vec++; if (Fifo_EMPTY !== 1'b1) begin n_err++; $display("FAIL err_empty: got %b want 1", Fifo_EMPTY); end
    n_vec++; if (n_wr != base)        begin n_err++; $display("FAIL err_no_wr: got %0d want %0d", n_wr, base); end
  endtask

  task automatic test_held;
    int base;
    base = n_wr;
    send(8'h7E, 1'b0, 1'b0, 3);
    repeat (40) @(negedge clk);
    n_vec++; if (n_wr != base + 1) begin n_err++; $display("FAIL held_one_wr: got %0d want %0d", n_wr - base, 1); end
    n_vec++; if (rxq[rxq.size()-1] !== 8'h7E) begin n_err++; $display("FAIL held_data: got %h want 7e", rxq[rxq.size()-1]); end
    n_vec++; if (Fifo_EMPTY !== 1'b1) begin n_err++; $display("FAIL held_empty: got %b want 1", Fifo_EMPTY); end
  endtask

  task automatic test_reset_mid;
    int base;
    base = n_wr;
    En = 1'b0;
    send(8'h11, 1'b0, 1'b0, 1);
    send(8'h22, 1'b0, 1'b0, 1);
    send(8'h33, 1'b0, 1'b0, 1);
    En = 1'b1;
    for (int k = 0; k < 50 && n_wr == base; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_vec++; if (Fifo_EMPTY !== 1'b0 || u_if.Tx_BUSY !== 1'b1) begin n_err++; $display("FAIL rmid_setup: got empty=%b busy=%b want 0/1", Fifo_EMPTY, u_if.Tx_BUSY); end
    reset = 1'b1;
    #1;
    n_vec++; if (u_if.Tx_WR !== 1'b0)   begin n_err++; $display("FAIL rmid_tx_wr: got %b want 0", u_if.Tx_WR); end
    n_vec++; if (Fifo_EMPTY !== 1'b1)   begin n_err++; $display("FAIL rmid_empty: got %b want 1", Fifo_EMPTY); end
    n_vec++; if (u_if.Tx_DATA !== 8'h00) begin n_err++; $display("FAIL rmid_tx_data: got %h want 00", u_if.Tx_DATA); end
    n_vec++; if (Err_CNT !== 8'h00 || Drop_CNT !== 8'h00) begin n_err++; $display("FAIL rmid_counters: got err=%h drop=%h want 00/00", Err_CNT, Drop_CNT); end
    @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    n_vec++; if (n_wr != base + 1) begin n_err++; $display("FAIL rmid_no_wr: got %0d want %0d", n_wr - base, 1); end
  endtask

  task automatic test_saturate;
    En = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h50 + 8'(i), 1'b0, 1'b0, 1);
    for (int i = 0; i < 254; i++) send(8'hEE, 1'b0, 1'b0, 1);
    n_vec++; if (Drop_CNT !== 8'hFE) begin n_err++; $display("FAIL sat_254: got %h want fe", Drop_CNT); end
    send(8'hEE, 1'b0, 1'b0, 1);
    n_vec++; if (Drop_CNT !== 8'hFF) begin n_err++; $display("FAIL sat_255: got %h want ff", Drop_CNT); end
    for (int i = 0; i < 3; i++) send(8'hEE, 1'b0, 1'b0, 1);
    n_vec++; if (Drop_CNT !== 8'hFF) begin n_err++; $display("FAIL sat_258: got %h want ff", Drop_CNT); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    En = 1'b0;
    u_if.Rx_DATA   = 8'h00;
    u_if.Rx_VALID  = 1'b0;
    u_if.Rx_FERROR = 1'b0;
    u_if.Rx_PERROR = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset;
    test_single;
    test_fill;
    test_errors;
    test_held;
    test_reset_mid;
    test_saturate;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
